// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: moves one SB/LB request from the execute stage onto a
// single-port word bus (req/gnt/rvalid), steers store bytes, sign-extends load
// bytes and returns them as a one-cycle register-file writeback pulse.
// mem_op encoding: 4'h0 = MEM_OP_NONE, 4'h1 = LB, 4'h2 = SB.
module mem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_op_i,
    input  logic [4:0]            reg_waddr_i,
    output logic                  stall_o,
    output logic                  reg_we_o,
    output logic [4:0]            reg_waddr_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic [3:0]            bus_be_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

    localparam logic [3:0] MEM_OP_NONE = 4'h0;
    localparam logic [3:0] MEM_OP_LB   = 4'h1;
    localparam logic [3:0] MEM_OP_SB   = 4'h2;

    localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       off_q;
    logic [4:0]       rd_q;
    logic             we_q;

    logic                  accept;
    logic [7:0]            rbyte;
    logic [DATA_WIDTH-1:0] rsext;
    logic                  unused_data;

    // Only SB-as-store and LB-as-load are legal; everything else is dropped.
    assign accept = req_valid_i && (mem_op_i != MEM_OP_NONE) &&
                    ((mem_op_i == MEM_OP_SB && mem_we_i) ||
                     (mem_op_i == MEM_OP_LB && !mem_we_i));

    // Upper store data bits are never used; only the low byte is replicated.
    assign unused_data = ^mem_data_i[DATA_WIDTH-1:8];

    // Byte select and sign extension for the load result.
    always_comb begin
        rbyte = bus_rdata_i[{off_q, 3'b000} +: 8];
        rsext = {{(DATA_WIDTH-8){rbyte[7]}}, rbyte};
    end

    // Stall is combinational in IDLE so the accepting cycle already holds exe;
    // gated by reset so every output is low while reset is asserted.
    assign stall_o = rst_i && ((state_q == StIdle) ? accept :
                               (state_q == StReq || state_q == StWait));

    // Access sequencer with registered bus and writeback outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_be_o    <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        off_q       <= mem_addr_i[1:0];
                        rd_q        <= reg_waddr_i;
                        we_q        <= mem_we_i;
                        cnt_q       <= '0;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        bus_be_o    <= 4'b0001 << mem_addr_i[1:0];
                        bus_wdata_o <= mem_we_i ? {(DATA_WIDTH/8){mem_data_i[7:0]}} : '0;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (bus_gnt_i || cnt_q == CNT_MAX) begin
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= '0;
                        bus_be_o    <= '0;
                        bus_wdata_o <= '0;
                    end
                    if (bus_gnt_i) begin
                        cnt_q   <= '0;
                        state_q <= we_q ? StDone : StWait;
                    end else if (cnt_q == CNT_MAX) begin
                        err_o   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWait: begin
                    if (bus_rvalid_i) begin
                        reg_we_o    <= 1'b1;
                        reg_waddr_o <= rd_q;
                        reg_wdata_o <= rsext;
                        state_q     <= StDone;
                    end else if (cnt_q == CNT_MAX) begin
                        err_o   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    // req_valid_i still shows the finished request here; ignore it.
                    reg_we_o    <= 1'b0;
                    reg_waddr_o <= '0;
                    reg_wdata_o <= '0;
                    err_o       <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the load/store request from the execute stage (address, data, write-enable, mem_op) onto a single-port word-addressed data bus with a req/gnt/rvalid handshake.
- Holds the pipeline while an access is in flight.
- Performs byte-lane steering for SB, and byte extraction plus sign extension for LB.
- Returns load data to the register-file write port as a one-cycle writeback pulse.

Parameters:
ADDR_WIDTH, 32, address width of exe request and bus
DATA_WIDTH, 32, data width of exe request and bus
TIMEOUT_CYCLES, 16, max cycles spent in REQ or WAIT before the access is aborted

Ports:
clk_i  in  1  single clock; all state updates on rising edge
rst_i  in  1  reset; asynchronous assert, active-low (0 = reset)
req_valid_i  in  1  exe stage presents a memory access this cycle
mem_addr_i  in  ADDR_WIDTH  byte address from exe
mem_data_i  in  DATA_WIDTH  store data from exe (byte in [7:0])
mem_we_i  in  1  1 = store, 0 = load
mem_op_i  in  4  `SB, `LB or `MEM_OP_NONE
reg_waddr_i  in  5  load destination register
stall_o  out  1  hold exe/ID stages
reg_we_o  out  1  load writeback strobe, one cycle
reg_waddr_o  out  5  writeback register index
reg_wdata_o  out  DATA_WIDTH  sign-extended load byte
err_o  out  1  one-cycle pulse on timeout abort
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write
bus_addr_o  out  ADDR_WIDTH  word-aligned address
bus_wdata_o  out  DATA_WIDTH  replicated store byte
bus_be_o  out  4  byte enables
bus_gnt_i  in  1  bus accepted request this cycle
bus_rvalid_i  in  1  read data valid
bus_rdata_i  in  DATA_WIDTH  read word

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; all outputs 0, including bus_req_o, stall_o, reg_we_o and err_o.
  - Captured request registers and the timeout counter are cleared.
  - Reset mid-access drops bus_req_o immediately, with no completion pulse.
- Accepted op: req_valid_i=1 and mem_op_i ∈ {`SB with mem_we_i=1, `LB with mem_we_i=0}.
  - Any other combination is ignored: no bus activity and no stall.
- IDLE:
  - stall_o = accepted op (combinational).
  - On an accepted op, capture addr/data/op/we/waddr and go to REQ.
- REQ:
  - bus_req_o=1; bus_addr_o = {addr[ADDR_WIDTH-1:2],2'b00}; bus_we_o = captured we.
  - Stores: bus_be_o = 4'b0001<<addr[1:0]; bus_wdata_o = {4{data[7:0]}}.
  - Loads: bus_be_o = 4'b0001<<addr[1:0]; bus_wdata_o = 0.
  - All bus fields are held stable until bus_gnt_i=1.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - bus_req_o drops the cycle after gnt.
  - stall_o=1.
- WAIT:
  - bus_req_o=0, stall_o=1.
  - On bus_rvalid_i=1, capture byte bus_rdata_i[8*addr[1:0]+:8], sign-extend it to DATA_WIDTH, and go to DONE.
  - rvalid arriving in IDLE or REQ is ignored.
- DONE (one cycle):
  - stall_o=0.
  - For a completed load: reg_we_o=1, with reg_waddr_o and reg_wdata_o valid.
  - req_valid_i is ignored in this cycle, because it still shows the old request. Next state is IDLE.
  - reg_waddr_o and reg_wdata_o are 0 outside DONE.
- Timeout:
  - The counter is cleared on entry to REQ and on entry to WAIT, and increments each cycle spent in those states.
  - When it reaches TIMEOUT_CYCLES-1 without gnt (REQ) or rvalid (WAIT), go to DONE with err_o=1, reg_we_o=0, and bus_req_o dropped.
  - gnt or rvalid arriving in the same cycle as the limit wins; no error is raised.
- Latency with zero-wait bus:
  - Store: accept c0, REQ+gnt c1, DONE c2. stall_o high for c0–c1.
  - Load: accept c0, REQ+gnt c1, WAIT+rvalid c2, DONE/writeback c3.
- Only one outstanding access; no pipelining of requests.

Test Plan:
1. SB addr=0x1003 data=0x000000A5, gnt in first REQ cycle -> bus_addr_o=0x1000, bus_be_o=4'b1000, bus_wdata_o=0xA5A5A5A5, bus_we_o=1; stall_o high 2 cycles; no reg_we_o.
2. LB addr=0x2001 rd=x5, gnt immediate, rvalid 3 cycles later with rdata=0x1234_80FF -> reg_we_o pulses once with reg_waddr_o=5, reg_wdata_o=0xFFFFFF80; stall released in the writeback cycle.
3. LB addr=0x2002 with rdata=0x007F0000 -> reg_wdata_o=0x0000007F; then a back-to-back SB presented in the cycle after DONE is accepted normally, and the old request held during DONE is not re-issued.
4. gnt held low for 4 cycles -> bus_req_o, bus_addr_o, bus_be_o and bus_wdata_o stable throughout; stall_o held; completes on the 5th cycle.
5. No gnt for TIMEOUT_CYCLES=16 -> err_o single pulse, reg_we_o=0, bus_req_o low, return to IDLE.
6. Assert rst_i=0 while in WAIT -> all outputs 0 without waiting for a clock edge. A subsequent rvalid produces no writeback. Separately, mem_op_i=`MEM_OP_NONE with req_valid_i=1 -> no stall and no bus_req_o.
